rename_stage_nw: RTL

- N-lane register-rename stage: the successor of the fixed two-lane combinational renamer.
- Sits between decode and dispatch.
- Maps each lane's logical sources to physical registers and allocates destinations from the freelist. Resolves intra-group RAW and WAW dependencies for any lane count.
- Registers the renamed group in an output pipeline stage with valid/ready handshake. Supports freelist back-pressure and flush.

---
 rtl/rename_stage_nw.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/rename_stage_nw.sv
// N-lane register rename stage with intra-group RAW/WAW bypass and a registered output stage.
// Optional performance counters are built when RENAME_PERF_CNT_EN is defined.
module rename_stage_nw #(
  parameter int WIDTH     = 2,
  parameter int LREG_W    = 5,
  parameter int PREG_W    = 6,
  parameter int PAYLOAD_W = 128,
  localparam int CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         in_valid,
  output logic                     in_ready,
  input  logic [WIDTH*LREG_W-1:0]  in_rs1,
  input  logic [WIDTH*LREG_W-1:0]  in_rs2,
  input  logic [WIDTH*LREG_W-1:0]  in_rd,
  input  logic [WIDTH-1:0]         in_src1_is_reg,
  input  logic [WIDTH-1:0]         in_src2_is_reg,
  input  logic [WIDTH-1:0]         in_need_to_wb,
  input  logic [WIDTH*PAYLOAD_W-1:0] in_payload,
  input  logic [WIDTH*PREG_W-1:0]  rat_prs1,
  input  logic [WIDTH*PREG_W-1:0]  rat_prs2,
  input  logic [WIDTH*PREG_W-1:0]  rat_prd,
  output logic [WIDTH-1:0]         rat_wr_en,
  output logic [WIDTH*LREG_W-1:0]  rat_wr_addr,
  output logic [WIDTH*PREG_W-1:0]  rat_wr_data,
  input  logic [CNT_W-1:0]         fl_free_cnt,
  input  logic [WIDTH*PREG_W-1:0]  fl_alloc_preg,
  output logic [CNT_W-1:0]         fl_alloc_cnt,
  output logic [WIDTH-1:0]         out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*LREG_W-1:0]  out_rs1,
  output logic [WIDTH*LREG_W-1:0]  out_rs2,
  output logic [WIDTH*LREG_W-1:0]  out_rd,
  output logic [WIDTH*PREG_W-1:0]  out_prs1,
  output logic [WIDTH*PREG_W-1:0]  out_prs2,
  output logic [WIDTH*PREG_W-1:0]  out_prd,
  output logic [WIDTH*PREG_W-1:0]  out_old_prd,
  output logic [WIDTH-1:0]         out_rd_valid,
  output logic [WIDTH*PAYLOAD_W-1:0] out_payload
`ifdef RENAME_PERF_CNT_EN
  ,
  output logic [31:0]              perf_renamed,
  output logic [31:0]              perf_fl_stall,
  output logic [31:0]              perf_bp_stall
`endif
);

  logic [WIDTH-1:0]        w_rd_valid;
  logic [PREG_W-1:0]       w_prd [WIDTH];
  logic [CNT_W-1:0]        w_need;
  logic [WIDTH*PREG_W-1:0] w_prs1, w_prs2, w_old_prd, w_prd_bus;
  logic [WIDTH-1:0]        w_youngest;
  logic                    w_out_free, w_in_ready, w_fire;

  logic [WIDTH-1:0]          r_out_valid, r_rd_valid;
  logic [WIDTH*LREG_W-1:0]   r_rs1, r_rs2, r_rd;
  logic [WIDTH*PREG_W-1:0]   r_prs1, r_prs2, r_prd, r_old_prd;
  logic [WIDTH*PAYLOAD_W-1:0] r_payload;

  // Each allocating lane takes the next freelist slot; slots compact over gaps.
  always_comb begin
    logic [CNT_W-1:0] v_cnt;
    v_cnt      = '0;
    w_rd_valid = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_rd_valid[i] = in_valid[i] & in_need_to_wb[i] & (in_rd[i*LREG_W +: LREG_W] != '0);
      w_prd[i] = '0;
      for (int k = 0; k < WIDTH; k++)
        if (CNT_W'(k) == v_cnt) w_prd[i] = fl_alloc_preg[k*PREG_W +: PREG_W];
      if (w_rd_valid[i]) v_cnt = v_cnt + CNT_W'(1);
    end
    w_need = v_cnt;
  end

  // Later older-lane matches overwrite earlier ones, so the youngest older writer wins.
  always_comb begin
    logic [LREG_W-1:0] v_rs1, v_rs2, v_rd, v_rdj;
    logic [PREG_W-1:0] v_p1, v_p2, v_old;
    w_prs1     = '0;
    w_prs2     = '0;
    w_old_prd  = '0;
    w_prd_bus  = '0;
    w_youngest = '0;
    for (int i = 0; i < WIDTH; i++) begin
      v_rs1 = in_rs1[i*LREG_W +: LREG_W];
      v_rs2 = in_rs2[i*LREG_W +: LREG_W];
      v_rd  = in_rd[i*LREG_W +: LREG_W];
      v_p1  = rat_prs1[i*PREG_W +: PREG_W];
      v_p2  = rat_prs2[i*PREG_W +: PREG_W];
      v_old = rat_prd[i*PREG_W +: PREG_W];
      w_youngest[i] = w_rd_valid[i];
      for (int j = 0; j < WIDTH; j++) begin
        v_rdj = in_rd[j*LREG_W +: LREG_W];
        if (j < i && w_rd_valid[j]) begin
          if (v_rdj == v_rs1) v_p1 = w_prd[j];
          if (v_rdj == v_rs2) v_p2 = w_prd[j];
          if (v_rdj == v_rd)  v_old = w_prd[j];
        end
        if (j > i && w_rd_valid[j] && v_rdj == v_rd) w_youngest[i] = 1'b0;
      end
      if (!(in_valid[i] & in_src1_is_reg[i]) || v_rs1 == '0) v_p1 = '0;
      if (!(in_valid[i] & in_src2_is_reg[i]) || v_rs2 == '0) v_p2 = '0;
      w_prs1[i*PREG_W +: PREG_W]    = v_p1;
      w_prs2[i*PREG_W +: PREG_W]    = v_p2;
      w_old_prd[i*PREG_W +: PREG_W] = v_old;
      w_prd_bus[i*PREG_W +: PREG_W] = w_prd[i];
    end
  end

  assign w_out_free = !(|r_out_valid) | out_ready;
  assign w_in_ready = reset_n & !flush & w_out_free & (fl_free_cnt >= w_need);
  assign w_fire     = (|in_valid) & w_in_ready;

  assign in_ready     = w_in_ready;
  assign fl_alloc_cnt = w_fire ? w_need : '0;
  assign rat_wr_en    = {WIDTH{w_fire}} & w_youngest;
  assign rat_wr_addr  = in_rd;
  assign rat_wr_data  = w_prd_bus;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= '0;
      r_rd_valid  <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_prs1      <= '0;
      r_prs2      <= '0;
      r_prd       <= '0;
      r_old_prd   <= '0;
      r_payload   <= '0;
    end else if (flush) begin
      r_out_valid <= '0;
      r_rd_valid  <= '0;
    end else if (w_fire) begin
      r_out_valid <= in_valid;
      r_rd_valid  <= w_rd_valid;
      r_rs1       <= in_rs1;
      r_rs2       <= in_rs2;
      r_rd        <= in_rd;
      r_prs1      <= w_prs1;
      r_prs2      <= w_prs2;
      r_prd       <= w_prd_bus;
      r_old_prd   <= w_old_prd;
      r_payload   <= in_payload;
    end else if (out_ready) begin
      r_out_valid <= '0;
      r_rd_valid  <= '0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_rd_valid = r_rd_valid;
  assign out_rs1      = r_rs1;
  assign out_rs2      = r_rs2;
  assign out_rd       = r_rd;
  assign out_prs1     = r_prs1;
  assign out_prs2     = r_prs2;
  assign out_prd      = r_prd;
  assign out_old_prd  = r_old_prd;
  assign out_payload  = r_payload;

`ifdef RENAME_PERF_CNT_EN
  logic [CNT_W-1:0] w_in_cnt;
  logic [31:0]      r_perf_renamed, r_perf_fl_stall, r_perf_bp_stall;

  always_comb begin
    w_in_cnt = '0;
    for (int i = 0; i < WIDTH; i++)
      if (in_valid[i]) w_in_cnt = w_in_cnt + CNT_W'(1);
  end

  // Counters keep running through flush; only reset clears them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_renamed  <= '0;
      r_perf_fl_stall <= '0;
      r_perf_bp_stall <= '0;
    end else begin
      if (w_fire) r_perf_renamed <= r_perf_renamed + 32'(w_in_cnt);
      if ((|in_valid) && w_out_free && !flush && (fl_free_cnt < w_need))
        r_perf_fl_stall <= r_perf_fl_stall + 32'd1;
      if ((|in_valid) && !w_out_free)
        r_perf_bp_stall <= r_perf_bp_stall + 32'd1;
    end
  end

  assign perf_renamed  = r_perf_renamed;
  assign perf_fl_stall = r_perf_fl_stall;
  assign perf_bp_stall = r_perf_bp_stall;
`endif

endmodule
